id_ex_pipe_reg: RTL and testbench



---
 rtl/id_ex_pipe_reg_pkg.sv | 29 ++
 rtl/pipe_lane_reg.sv | 79 +++++++
 rtl/id_ex_pipe_reg.sv | 147 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared constants and stage-control type for the ID/EX pipeline register.
// Used by id_ex_pipe_reg and pipe_lane_reg.
package id_ex_pipe_reg_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic Stop         = 1'b1;
  localparam logic NonStop      = 1'b0;
  localparam logic WriteDisable = 1'b0;

  localparam logic [31:0] ZeroWord   = 32'h0;
  localparam logic [4:0]  NOPRegAddr = 5'h0;

  // NOP encodings; NOP_PAYLOAD is built from these.
  localparam logic [7:0] EXE_NOP_OP  = 8'h00;
  localparam logic [2:0] EXE_RES_NOP = 3'h0;

  typedef enum logic [1:0] {
    CTL_LOAD,
    CTL_HOLD,
    CTL_BUBBLE
  } stage_ctrl_e;

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// One issue lane of the ID/EX register.
// Applies the shared LOAD/HOLD/BUBBLE decision to one lane.
module pipe_lane_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int PAYLOAD_W = 48,
  parameter int REG_W     = 32,
  parameter int RADDR_W   = 5,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
  input  logic                 clk,
  input  stage_ctrl_e          ctrl_i,
  input  logic                 valid_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [REG_W-1:0]     reg1_i,
  input  logic [REG_W-1:0]     reg2_i,
  input  logic [RADDR_W-1:0]   wd_i,
  input  logic                 wreg_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [REG_W-1:0]     reg1_o,
  output logic [REG_W-1:0]     reg2_o,
  output logic [RADDR_W-1:0]   wd_o,
  output logic                 wreg_o
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [REG_W-1:0]     reg1_q, reg1_d;
  logic [REG_W-1:0]     reg2_q, reg2_d;
  logic [RADDR_W-1:0]   wd_q, wd_d;
  logic                 wreg_q, wreg_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    unique case (ctrl_i)
      CTL_LOAD: begin
        valid_d   = valid_i;
        payload_d = payload_i;
        reg1_d    = reg1_i;
        reg2_d    = reg2_i;
        wd_d      = wd_i;
        // invalid lanes must never write back
        wreg_d    = wreg_i & valid_i;
      end
      CTL_BUBBLE: begin
        valid_d   = 1'b0;
        payload_d = NOP_PAYLOAD;
        reg1_d    = '0;
        reg2_d    = '0;
        wd_d      = '0;
        wreg_d    = WriteDisable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    payload_q <= payload_d;
    reg1_q    <= reg1_d;
    reg2_q    <= reg2_d;
    wd_q      <= wd_d;
    wreg_q    <= wreg_d;
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
  assign reg1_o    = reg1_q;
  assign reg2_o    = reg2_q;
  assign wd_o      = wd_q;
  assign wreg_o    = wreg_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Multi-lane ID/EX pipeline register with flush, delay-slot and hold watchdog.
// ID_EX_PIPE_STATS_EN adds saturating bubble_cnt / hold_cnt outputs.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int PAYLOAD_W = 48,
  parameter int REG_W     = 32,
  parameter int RADDR_W   = 5,
  parameter int STAGE_IDX = 2,
  parameter int STALL_W   = 6,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
  parameter int HOLD_MAX  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [STALL_W-1:0]           stall,
  input  logic                         flush,
  input  logic [LANES-1:0]             id_valid,
  input  logic [LANES*PAYLOAD_W-1:0]   id_payload,
  input  logic [LANES*REG_W-1:0]       id_reg1,
  input  logic [LANES*REG_W-1:0]       id_reg2,
  input  logic [LANES*RADDR_W-1:0]     id_wd,
  input  logic [LANES-1:0]             id_wreg,
  input  logic                         id_next_in_ds,
  output logic [LANES-1:0]             ex_valid,
  output logic [LANES*PAYLOAD_W-1:0]   ex_payload,
  output logic [LANES*REG_W-1:0]       ex_reg1,
  output logic [LANES*REG_W-1:0]       ex_reg2,
  output logic [LANES*RADDR_W-1:0]     ex_wd,
  output logic [LANES-1:0]             ex_wreg,
  output logic                         id_is_in_ds,
  output logic                         hold_timeout
`ifdef ID_EX_PIPE_STATS_EN
  ,
  output logic [31:0]                  bubble_cnt,
  output logic [31:0]                  hold_cnt
`endif
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_MAX);

  stage_ctrl_e ctrl, lane_ctrl;
  logic        stall_unused;

  assign stall_unused = ^stall;

  always_comb begin
    ctrl = CTL_HOLD;
    if (flush) begin
      ctrl = CTL_BUBBLE;
    end else if (stall[STAGE_IDX] == Stop &&
                 stall[STAGE_IDX+1] == NonStop) begin
      ctrl = CTL_BUBBLE;
    end else if (stall[STAGE_IDX] == NonStop) begin
      ctrl = CTL_LOAD;
    end
  end

  // reset clears the lanes exactly like a bubble
  assign lane_ctrl = (rst == RstEnable) ? CTL_BUBBLE : ctrl;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pipe_lane_reg #(
      .PAYLOAD_W  (PAYLOAD_W),
      .REG_W      (REG_W),
      .RADDR_W    (RADDR_W),
      .NOP_PAYLOAD(NOP_PAYLOAD)
    ) u_lane (
      .clk      (clk),
      .ctrl_i   (lane_ctrl),
      .valid_i  (id_valid[i]),
      .payload_i(id_payload[i*PAYLOAD_W +: PAYLOAD_W]),
      .reg1_i   (id_reg1[i*REG_W +: REG_W]),
      .reg2_i   (id_reg2[i*REG_W +: REG_W]),
      .wd_i     (id_wd[i*RADDR_W +: RADDR_W]),
      .wreg_i   (id_wreg[i]),
      .valid_o  (ex_valid[i]),
      .payload_o(ex_payload[i*PAYLOAD_W +: PAYLOAD_W]),
      .reg1_o   (ex_reg1[i*REG_W +: REG_W]),
      .reg2_o   (ex_reg2[i*REG_W +: REG_W]),
      .wd_o     (ex_wd[i*RADDR_W +: RADDR_W]),
      .wreg_o   (ex_wreg[i])
    );
  end

  logic          ds_q, ds_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          to_q, to_d;

  always_comb begin
    ds_d   = ds_q;
    hcnt_d = '0;
    to_d   = to_q;
    unique case (ctrl)
      CTL_LOAD:   ds_d = id_next_in_ds;
      CTL_BUBBLE: ds_d = 1'b0;
      CTL_HOLD: begin
        hcnt_d = (hcnt_q == HoldMax) ? hcnt_q : hcnt_q + 1'b1;
        if (hcnt_d == HoldMax) to_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      ds_q   <= 1'b0;
      hcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      ds_q   <= ds_d;
      hcnt_q <= hcnt_d;
      to_q   <= to_d;
    end
  end

  assign id_is_in_ds  = ds_q;
  assign hold_timeout = to_q;

`ifdef ID_EX_PIPE_STATS_EN
  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] hstat_q, hstat_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    hstat_d = hstat_q;
    if (ctrl == CTL_BUBBLE) bcnt_d = sat_inc32(bcnt_q);
    if (ctrl == CTL_HOLD) hstat_d = sat_inc32(hstat_q);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      bcnt_q  <= '0;
      hstat_q <= '0;
    end else begin
      bcnt_q  <= bcnt_d;
      hstat_q <= hstat_d;
    end
  end

  assign bubble_cnt = bcnt_q;
  assign hold_cnt   = hstat_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg (2 lanes, HOLD_MAX = 4).
// Reference model plus directed literal checks.
module tb_id_ex_pipe_reg;

  localparam int L  = 2;
  localparam int P  = 48;
  localparam int R  = 32;
  localparam int A  = 5;
  localparam int S  = 2;
  localparam int SW = 6;
  localparam int HM = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [SW-1:0]   stall;
  logic            flush;
  logic [L-1:0]    id_valid;
  logic [L*P-1:0]  id_payload;
  logic [L*R-1:0]  id_reg1;
  logic [L*R-1:0]  id_reg2;
  logic [L*A-1:0]  id_wd;
  logic [L-1:0]    id_wreg;
  logic            id_next_in_ds;
  logic [L-1:0]    ex_valid;
  logic [L*P-1:0]  ex_payload;
  logic [L*R-1:0]  ex_reg1;
  logic [L*R-1:0]  ex_reg2;
  logic [L*A-1:0]  ex_wd;
  logic [L-1:0]    ex_wreg;
  logic            id_is_in_ds;
  logic            hold_timeout;
`ifdef ID_EX_PIPE_STATS_EN
  logic [31:0]     bubble_cnt;
  logic [31:0]     hold_cnt;
`endif

  id_ex_pipe_reg #(
    .LANES(L), .PAYLOAD_W(P), .REG_W(R), .RADDR_W(A),
    .STAGE_IDX(S), .STALL_W(SW), .NOP_PAYLOAD('0), .HOLD_MAX(HM)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_payload(id_payload),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd),
    .id_wreg(id_wreg), .id_next_in_ds(id_next_in_ds),
    .ex_valid(ex_valid), .ex_payload(ex_payload),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd),
    .ex_wreg(ex_wreg), .id_is_in_ds(id_is_in_ds),
    .hold_timeout(hold_timeout)
`ifdef ID_EX_PIPE_STATS_EN
    , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: what EX must hold after each edge
  logic [L-1:0]   m_valid;
  logic [L*P-1:0] m_payload;
  logic [L*R-1:0] m_r1, m_r2;
  logic [L*A-1:0] m_wd;
  logic [L-1:0]   m_wreg;
  logic           m_ds, m_to;
  int             m_run, m_bs, m_hs;
  bit             m_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1;
      m_valid <= '0; m_payload <= '0; m_r1 <= '0; m_r2 <= '0;
      m_wd <= '0; m_wreg <= '0; m_ds <= 0; m_to <= 0;
      m_run <= 0; m_bs <= 0; m_hs <= 0;
    end else if (flush || (stall[S] && !stall[S+1])) begin
      m_valid <= '0; m_payload <= '0; m_r1 <= '0; m_r2 <= '0;
      m_wd <= '0; m_wreg <= '0; m_ds <= 0;
      m_run <= 0; m_bs <= m_bs + 1;
    end else if (!stall[S]) begin
      m_valid <= id_valid; m_payload <= id_payload;
      m_r1 <= id_reg1; m_r2 <= id_reg2; m_wd <= id_wd;
      m_wreg <= id_wreg & id_valid; m_ds <= id_next_in_ds;
      m_run <= 0;
    end else begin
      m_run <= (m_run + 1 > HM) ? HM : m_run + 1;
      if (m_run + 1 >= HM) m_to <= 1;
      m_hs <= m_hs + 1;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_valid", 128'(ex_valid), 128'(m_valid));
      chk("m_payload", 128'(ex_payload), 128'(m_payload));
      chk("m_reg1", 128'(ex_reg1), 128'(m_r1));
      chk("m_reg2", 128'(ex_reg2), 128'(m_r2));
      chk("m_wd", 128'(ex_wd), 128'(m_wd));
      chk("m_wreg", 128'(ex_wreg), 128'(m_wreg));
      chk("m_ds", 128'(id_is_in_ds), 128'(m_ds));
      chk("m_timeout", 128'(hold_timeout), 128'(m_to));
`ifdef ID_EX_PIPE_STATS_EN
      chk("m_bubble_cnt", 128'(bubble_cnt), 128'(m_bs));
      chk("m_hold_cnt", 128'(hold_cnt), 128'(m_hs));
`endif
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = '1; flush = 1;
    id_valid = '1; id_payload = '1; id_reg1 = '1; id_reg2 = '1;
    id_wd = '1; id_wreg = '1; id_next_in_ds = 1;
    cyc(2);
    chk("rst_valid", 128'(ex_valid), 128'h0);
    chk("rst_payload", 128'(ex_payload), 128'h0);
    chk("rst_reg1", 128'(ex_reg1), 128'h0);
    chk("rst_wreg", 128'(ex_wreg), 128'h0);
    chk("rst_ds", 128'(id_is_in_ds), 128'h0);
    chk("rst_to", 128'(hold_timeout), 128'h0);

    rst = 0; stall = '0; flush = 0;
    id_valid = 2'b11; id_wreg = 2'b11; id_next_in_ds = 1;
    id_payload = {48'hAAAA_0000_0001, 48'h1234_5678_9ABC};
    id_reg1 = {32'h1111_1111, 32'hDEAD_BEEF};
    id_reg2 = {32'h2222_2222, 32'h0000_0042};
    id_wd = {5'd3, 5'd7};
    cyc();
    chk("load_reg1", 128'(ex_reg1[31:0]), 128'hDEAD_BEEF);
    chk("load_wd", 128'(ex_wd), 128'h067);
    chk("load_wreg", 128'(ex_wreg), 128'h3);
    chk("load_ds", 128'(id_is_in_ds), 128'h1);

    stall = 6'b001111; id_reg1 = {32'h3333_3333, 32'hCAFE_F00D};
    cyc(3);
    chk("hold_reg1", 128'(ex_reg1[31:0]), 128'hDEAD_BEEF);
    chk("hold_to", 128'(hold_timeout), 128'h0);
    stall = '0;
    cyc();
    chk("release_reg1", 128'(ex_reg1[31:0]), 128'hCAFE_F00D);

    stall = 6'b000111;
    cyc();
    chk("bub_valid", 128'(ex_valid), 128'h0);
    chk("bub_wreg", 128'(ex_wreg), 128'h0);
    chk("bub_wd", 128'(ex_wd), 128'h0);

    stall = '0;
    cyc();
    chk("ds_set", 128'(id_is_in_ds), 128'h1);
    stall = 6'b001111; flush = 1;
    cyc();
    chk("flush_valid", 128'(ex_valid), 128'h0);
    chk("flush_ds", 128'(id_is_in_ds), 128'h0);

    flush = 0; stall = '0; id_valid = 2'b10; id_wreg = 2'b11;
    cyc();
    chk("ml_wreg", 128'(ex_wreg), 128'h2);
    chk("ml_valid", 128'(ex_valid), 128'h2);

    rst = 1;
    cyc();
    rst = 0; id_valid = 2'b11;
    cyc();
    stall = 6'b001111;
    cyc(3);
    chk("wd3_to", 128'(hold_timeout), 128'h0);
    cyc();
    chk("wd4_to", 128'(hold_timeout), 128'h1);
`ifdef ID_EX_PIPE_STATS_EN
    chk("wd_hold_cnt", 128'(hold_cnt), 128'd4);
    chk("wd_bubble_cnt", 128'(bubble_cnt), 128'd0);
`endif
    stall = '0;
    cyc(2);
    chk("wd_sticky", 128'(hold_timeout), 128'h1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: stall = 6'b000000;
        1: stall = 6'b000111;
        2: stall = 6'b001111;
        default: stall = 6'b111111;
      endcase
      flush = ($urandom_range(0, 7) == 0);
      rst = (i == 20);
      id_valid = 2'($urandom);
      id_wreg = 2'($urandom);
      id_next_in_ds = 1'($urandom);
      id_payload = {16'($urandom), 32'($urandom), 16'($urandom), 32'($urandom)};
      id_reg1 = {32'($urandom), 32'($urandom)};
      id_reg2 = {32'($urandom), 32'($urandom)};
      id_wd = 10'($urandom);
      cyc();
    end
    rst = 1;
    cyc();
    chk("final_rst_to", 128'(hold_timeout), 128'h0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule
